aibcr3aux_osc_clkgate_ctrl: RTL and testbench



---
 rtl/aibcr3aux_clkgate_pkg.sv | 25 ++
 rtl/aibcr3aux_sync_nff.sv | 25 ++
 rtl/aibcr3aux_osc_clkgate_ctrl.sv | 108 ++++++++++
 tb/tb_aibcr3aux_osc_clkgate_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/aibcr3aux_clkgate_pkg.sv
// Shared state encoding and default settle timing for the aux-osc clock-gate controller.
package aibcr3aux_clkgate_pkg;

    localparam logic [1:0] ENC_OFF     = 2'd0;
    localparam logic [1:0] ENC_ENABLE  = 2'd1;
    localparam logic [1:0] ENC_ON      = 2'd2;
    localparam logic [1:0] ENC_DISABLE = 2'd3;

    typedef enum logic [1:0] {
        ST_OFF     = ENC_OFF,
        ST_ENABLE  = ENC_ENABLE,
        ST_ON      = ENC_ON,
        ST_DISABLE = ENC_DISABLE
    } gate_state_e;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_ON_DLY      = 4;
    localparam int DEF_OFF_DLY     = 4;
    localparam int DEF_CNT_W       = 4;

    function automatic logic is_busy(gate_state_e s);
        return (s == ST_ENABLE) || (s == ST_DISABLE);
    endfunction

endpackage

// File: rtl/aibcr3aux_sync_nff.sv
// N-stage reset-to-0 level synchronizer.
module aibcr3aux_sync_nff #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] sync_q;
    logic [N-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[N-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    assign q = sync_q[N-1];

endmodule

// File: rtl/aibcr3aux_osc_clkgate_ctrl.sv
// Aux-osc clock-gate initiator: sequences clk_en and gate_ack around fixed settle windows.
// Optional scan override enabled by defining AIBCR3AUX_CLKGATE_SCAN_EN.
module aibcr3aux_osc_clkgate_ctrl
    import aibcr3aux_clkgate_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int ON_DLY      = DEF_ON_DLY,
    parameter int OFF_DLY     = DEF_OFF_DLY,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic       ckin,
    input  logic       rstb,
    input  logic       gate_req,
`ifdef AIBCR3AUX_CLKGATE_SCAN_EN
    input  logic       scan_mode_n,
`endif
    output logic       clk_en,
    output logic       gate_ack,
    output logic       busy,
    output logic [1:0] fsm_state
);

    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_DLY - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_DLY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    gate_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_en_q, clk_en_d;
    logic             gate_ack_q, gate_ack_d;
    logic             busy_q, busy_d;
    logic             req_s;
    logic             sync_rst_n;

`ifdef AIBCR3AUX_CLKGATE_SCAN_EN
    // Scan holds the request synchronizer clear so the FSM sees no request.
    assign sync_rst_n = rstb & scan_mode_n;
`else
    assign sync_rst_n = rstb;
`endif

    aibcr3aux_sync_nff #(.N(SYNC_STAGES)) u_req_sync (
        .clk   (ckin),
        .rst_n (sync_rst_n),
        .d     (gate_req),
        .q     (req_s)
    );

    // Transitions out of ENABLE/DISABLE wait only on the counter: the gate
    // cell may already have sampled en, so a request change cannot abort.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            ST_OFF: begin
                if (req_s) begin
                    state_d = ST_ENABLE;
                    cnt_d   = ON_LOAD;
                end
            end
            ST_ENABLE: begin
                if (cnt_q == '0) state_d = ST_ON;
                else             cnt_d   = cnt_q - CNT_ONE;
            end
            ST_ON: begin
                if (!req_s) begin
                    state_d = ST_DISABLE;
                    cnt_d   = OFF_LOAD;
                end
            end
            ST_DISABLE: begin
                if (cnt_q == '0) state_d = ST_OFF;
                else             cnt_d   = cnt_q - CNT_ONE;
            end
            default: state_d = ST_OFF;
        endcase
        clk_en_d   = (state_d == ST_ENABLE) || (state_d == ST_ON);
        gate_ack_d = (state_d == ST_ON) || (state_d == ST_DISABLE);
        busy_d     = is_busy(state_d);
    end

    always_ff @(posedge ckin or negedge rstb) begin
        if (!rstb) begin
            state_q    <= ST_OFF;
            cnt_q      <= '0;
            clk_en_q   <= 1'b0;
            gate_ack_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clk_en_q   <= clk_en_d;
            gate_ack_q <= gate_ack_d;
            busy_q     <= busy_d;
        end
    end

`ifdef AIBCR3AUX_CLKGATE_SCAN_EN
    assign clk_en   = clk_en_q | ~scan_mode_n;
    assign gate_ack = gate_ack_q | ~scan_mode_n;
`else
    assign clk_en   = clk_en_q;
    assign gate_ack = gate_ack_q;
`endif
    assign busy      = busy_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_aibcr3aux_osc_clkgate_ctrl.sv
// Vector-table bench for the aux-osc clock-gate controller with an expected-result queue.
module tb_aibcr3aux_osc_clkgate_ctrl;

    localparam logic [1:0] S_OFF = 2'd0;
    localparam logic [1:0] S_EN  = 2'd1;
    localparam logic [1:0] S_ON  = 2'd2;
    localparam logic [1:0] S_DIS = 2'd3;

    typedef struct packed {
        logic       rstb;
        logic       req;
        logic       en;
        logic       ack;
        logic       busy;
        logic [1:0] st;
    } vec_t;

    logic       ckin = 1'b0;
    logic       rstb = 1'b0;
    logic       gate_req = 1'b1;
    logic       scan_mode_n = 1'b1;
    logic       clk_en, gate_ack, busy;
    logic [1:0] fsm_state;

    int checks = 0;
    int errors = 0;

    vec_t       vecs[$];
    logic [4:0] sb[$];

    always #5 ckin = ~ckin;

    aibcr3aux_osc_clkgate_ctrl dut (
        .ckin        (ckin),
        .rstb        (rstb),
        .gate_req    (gate_req),
`ifdef AIBCR3AUX_CLKGATE_SCAN_EN
        .scan_mode_n (scan_mode_n),
`endif
        .clk_en      (clk_en),
        .gate_ack    (gate_ack),
        .busy        (busy),
        .fsm_state   (fsm_state)
    );

    // Expected outputs follow from the state the controller should be in.
    task automatic add(input logic r, input logic q, input logic [1:0] st, input int n);
        vec_t v;
        v.rstb = r;
        v.req  = q;
        v.st   = st;
        v.en   = (st == S_EN) || (st == S_ON);
        v.ack  = (st == S_ON) || (st == S_DIS);
        v.busy = (st == S_EN) || (st == S_DIS);
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got {en,ack,busy,st}=%b want %b", name, act, exp);
        end
    endtask

    function automatic logic [4:0] outs();
        return {clk_en, gate_ack, busy, fsm_state};
    endfunction

    initial begin
        logic       prev_rstb;
        logic [4:0] exp;

        add(0, 1, S_OFF, 5);   // reset held with request high
        add(1, 1, S_OFF, 2);   // two sync stages
        add(1, 1, S_EN,  4);
        add(1, 1, S_ON,  3);
        add(1, 0, S_ON,  2);   // disable path
        add(1, 0, S_DIS, 4);
        add(1, 0, S_OFF, 3);
        add(1, 1, S_OFF, 2);   // enable, then withdraw one cycle after clk_en
        add(1, 1, S_EN,  1);
        add(1, 0, S_EN,  3);
        add(1, 0, S_ON,  1);   // single-cycle ack in ON
        add(1, 0, S_DIS, 1);
        add(1, 1, S_DIS, 3);   // reassert during DISABLE
        add(1, 1, S_OFF, 1);   // single-cycle OFF
        add(1, 1, S_EN,  4);
        add(1, 1, S_ON,  2);
        add(1, 0, S_ON,  2);
        add(1, 0, S_DIS, 4);
        add(1, 0, S_OFF, 1);
        add(1, 1, S_OFF, 2);
        add(1, 1, S_EN,  2);   // cnt now 2
        add(0, 1, S_OFF, 3);   // reset mid-ENABLE
        add(1, 1, S_OFF, 2);
        add(1, 1, S_EN,  4);
        add(1, 1, S_ON,  2);
        add(1, 0, S_ON,  2);
        add(1, 0, S_DIS, 4);
        add(1, 0, S_OFF, 2);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge ckin);
            prev_rstb = rstb;
            rstb      = vecs[i].rstb;
            gate_req  = vecs[i].req;
            if (prev_rstb && !rstb) begin
                #1 chk($sformatf("async_rst_%0d", i), outs(), 5'b0);
            end
            sb.push_back({vecs[i].en, vecs[i].ack, vecs[i].busy, vecs[i].st});
            @(posedge ckin);
            #1;
            exp = sb.pop_front();
            chk($sformatf("vec_%0d", i), outs(), exp);
        end

`ifdef AIBCR3AUX_CLKGATE_SCAN_EN
        @(negedge ckin);
        scan_mode_n = 1'b0;
        gate_req    = 1'b1;
        #1 chk("scan_force", outs(), {1'b1, 1'b1, 1'b0, S_OFF});
        for (int i = 0; i < 4; i++) begin
            @(posedge ckin);
            #1 chk($sformatf("scan_hold_%0d", i), outs(), {1'b1, 1'b1, 1'b0, S_OFF});
        end
        @(negedge ckin);
        scan_mode_n = 1'b1;
        gate_req    = 1'b0;
        #1 chk("scan_release", outs(), {1'b0, 1'b0, 1'b0, S_OFF});
        @(posedge ckin);
        #1 chk("scan_after", outs(), {1'b0, 1'b0, 1'b0, S_OFF});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
